sincos_result_buffer: RTL and testbench

- Sits directly downstream of the 16-stage sin/cos CORDIC pipeline. The CORDIC has no valid or handshake signals of its own.
- Tracks which cycles carry a real angle through a valid shift register aligned to the CORDIC latency, then captures the matching X/Y (cos/sin) results into a small FIFO.
- Presents results on a ready/valid output interface.
- Gives upstream credit-based back-pressure through in_ready, so no result is lost when the consumer stalls.

---
 rtl/sincos_result_buffer.sv | 120 ++++++++++++
 tb/tb_sincos_result_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sincos_result_buffer.sv
// Result buffer behind a handshake-less CORDIC pipeline: tracks valid angles through a
// latency-aligned shift register and queues the matching results behind a credit-gated input.
module sincos_result_buffer #(
    parameter int XY_SZ   = 16,
    parameter int LATENCY = 16,
    parameter int DEPTH   = 8,
    parameter int CW      = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [XY_SZ:0] cordic_x,
    input  logic signed [XY_SZ:0] cordic_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [XY_SZ:0] out_cos,
    output logic signed [XY_SZ:0] out_sin,
    output logic [CW-1:0]       out_count,
    output logic                err_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = XY_SZ + 1;

    logic [LATENCY-1:0] vsr_q, vsr_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic               err_drop_q, err_drop_d;
    logic [DW-1:0]      mem_x_q [DEPTH];
    logic [DW-1:0]      mem_y_q [DEPTH];
    logic [DW-1:0]      mem_x_d [DEPTH];
    logic [DW-1:0]      mem_y_d [DEPTH];
    logic [DEPTH-1:0]   mem_we;
    logic [CW:0]        credit_used;
    logic               accept;
    logic               push;
    logic               pop;

    // Credit counts both buffered and still-in-pipeline results, so a landing push always has room.
    assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
    assign in_ready    = credit_used < (CW+1)'(DEPTH);
    assign accept      = in_valid && in_ready;
    assign push        = vsr_q[LATENCY-1];
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign mem_we[gi] = push && (wr_ptr_q == PW'(gi));
        end
    endgenerate

    always_comb begin
        vsr_d    = vsr_q << 1;
        vsr_d[0] = accept;

        inflight_d = inflight_q;
        case ({accept, push})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        err_drop_d = err_drop_q || (in_valid && !in_ready);

        for (int i = 0; i < DEPTH; i++) begin
            mem_x_d[i] = mem_x_q[i];
            mem_y_d[i] = mem_y_q[i];
            if (mem_we[i]) begin
                mem_x_d[i] = cordic_x;
                mem_y_d[i] = cordic_y;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vsr_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            err_drop_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_x_q[i] <= '0;
                mem_y_q[i] <= '0;
            end
        end else begin
            vsr_q      <= vsr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            err_drop_q <= err_drop_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_x_q[i] <= mem_x_d[i];
                mem_y_q[i] <= mem_y_d[i];
            end
        end
    end

    assign out_cos   = mem_x_q[rd_ptr_q];
    assign out_sin   = mem_y_q[rd_ptr_q];
    assign out_count = count_q;
    assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_sincos_result_buffer.sv
// Bench for sincos_result_buffer: a delay-line stand-in for the CORDIC plus a queue-based
// reference model, a directed vector table, hand-written corner sequences and random traffic.
module tb_sincos_result_buffer;

    localparam int XY_SZ = 16;
    localparam int LAT   = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [XY_SZ:0]  cordic_x, cordic_y;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [XY_SZ:0]  out_cos, out_sin;
    logic [CW-1:0]          out_count;
    logic                   err_drop;

    logic signed [XY_SZ:0]  ang_x, ang_y;
    logic signed [XY_SZ:0]  px [LAT];
    logic signed [XY_SZ:0]  py [LAT];

    always #5 clock = ~clock;

    sincos_result_buffer #(.XY_SZ(XY_SZ), .LATENCY(LAT), .DEPTH(DEPTH), .CW(CW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .cordic_x(cordic_x), .cordic_y(cordic_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cos(out_cos), .out_sin(out_sin),
        .out_count(out_count), .err_drop(err_drop)
    );

    // CORDIC stand-in: whatever is driven as the "angle" reappears LAT cycles later.
    always @(posedge clock) begin
        px[0] <= ang_x;
        py[0] <= ang_y;
        for (int i = 1; i < LAT; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
        end
    end
    assign cordic_x = px[LAT-1];
    assign cordic_y = py[LAT-1];

    typedef struct { int due; int x; int y; } flight_t;
    typedef struct { int x; int y; } res_t;
    typedef struct {
        bit iv; bit ordy; int ax; int ay;
        bit e_valid; bit e_rdy; int e_count; int e_cos; int e_sin;
    } vec_t;

    flight_t m_flight[$];
    res_t    m_fifo[$];
    bit      m_err;
    int      cyc;
    int      n_chk, n_fail;
    int      got[$];
    bit      chk_en, rec_en;
    vec_t    tv[20];
    int      sent, acc;
    bit      iv_r, or_r;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic bit m_ready();
        return (m_fifo.size() + m_flight.size()) < DEPTH;
    endfunction

    task automatic model_check();
        chk("in_ready", int'(in_ready), int'(m_ready()));
        chk("out_valid", int'(out_valid), int'(m_fifo.size() != 0));
        chk("out_count", int'(out_count), m_fifo.size());
        chk("err_drop", int'(err_drop), int'(m_err));
        if (m_fifo.size() != 0) begin
            chk("out_cos", int'(out_cos), m_fifo[0].x);
            chk("out_sin", int'(out_sin), m_fifo[0].y);
        end
    endtask

    // Advances the reference model across one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit rdy;
        flight_t f;
        res_t r;
        rdy = m_ready();
        if (in_valid && !rdy) m_err = 1'b1;
        if (out_ready && m_fifo.size() != 0) void'(m_fifo.pop_front());
        if (m_flight.size() != 0 && m_flight[0].due == cyc) begin
            f = m_flight.pop_front();
            r.x = f.x;
            r.y = f.y;
            m_fifo.push_back(r);
        end
        if (in_valid && rdy) begin
            f.due = cyc + LAT;
            f.x = int'(ang_x);
            f.y = int'(ang_y);
            m_flight.push_back(f);
        end
    endtask

    task automatic step(input bit iv, input bit ordy, input int ax, input int ay);
        in_valid  = iv;
        out_ready = ordy;
        ang_x     = 17'(ax);
        ang_y     = 17'(ay);
        #1;
        if (chk_en) model_check();
        if (rec_en && out_valid && out_ready) got.push_back(int'(out_cos));
        model_edge();
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m_flight.delete();
        m_fifo.delete();
        m_err = 1'b0;
        @(posedge clock);
        @(negedge clock);
        cyc++;
        reset = 1'b0;
    endtask

    task automatic check_order(input string nm, input int n, input int base);
        chk({nm, "_count"}, got.size(), n);
        for (int k = 0; k < n && k < got.size(); k++) chk(nm, got[k], base + k);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ang_x = '0; ang_y = '0;
        n_chk = 0; n_fail = 0; cyc = 0; chk_en = 1'b0; rec_en = 1'b0; m_err = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tv[i].iv = 1'b0; tv[i].ordy = 1'b1;
            tv[i].ax = 500 + i; tv[i].ay = -(500 + i);
            tv[i].e_valid = 1'b0; tv[i].e_rdy = 1'b1; tv[i].e_count = 0;
            tv[i].e_cos = 0; tv[i].e_sin = 0;
        end
        tv[0].iv = 1'b1; tv[0].ax = 32000; tv[0].ay = 0;
        tv[17].e_valid = 1'b1; tv[17].e_count = 1; tv[17].e_cos = 32000; tv[17].e_sin = 0;

        @(negedge clock);
        do_reset();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_err_drop", int'(err_drop), 0);
        chk("rst_out_cos", int'(out_cos), 0);
        chk("rst_out_sin", int'(out_sin), 0);

        // Single angle: result visible LAT+1 cycles after acceptance.
        for (int i = 0; i < 20; i++) begin
            chk("vec_out_valid", int'(out_valid), int'(tv[i].e_valid));
            chk("vec_in_ready", int'(in_ready), int'(tv[i].e_rdy));
            chk("vec_out_count", int'(out_count), tv[i].e_count);
            if (tv[i].e_valid) begin
                chk("vec_out_cos", int'(out_cos), tv[i].e_cos);
                chk("vec_out_sin", int'(out_sin), tv[i].e_sin);
            end
            step(tv[i].iv, tv[i].ordy, tv[i].ax, tv[i].ay);
        end

        // Back-to-back stream of 20 with a free-running consumer.
        do_reset();
        chk_en = 1'b1; rec_en = 1'b1; got.delete(); sent = 0;
        for (int c = 0; c < 120; c++) begin
            iv_r = (sent < 20) && m_ready();
            step(iv_r, 1'b1, sent, -sent);
            if (iv_r) sent++;
        end
        check_order("stream_order", 20, 0);
        chk("stream_err_drop", int'(err_drop), 0);

        // Consumer stall with in_valid held high: credit runs out after 8 and drops are flagged.
        do_reset();
        rec_en = 1'b0; acc = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 24) chk("stall_count_at_24", int'(out_count), 8);
            if (in_ready) acc++;
            step(1'b1, 1'b0, c, -c);
        end
        chk("stall_accepts", acc, 8);
        chk("stall_err_drop", int'(err_drop), 1);
        rec_en = 1'b1; got.delete();
        for (int c = 0; c < 12; c++) step(1'b0, 1'b1, 0, 0);
        check_order("stall_drain", 8, 0);
        chk("stall_ready_after_drain", int'(in_ready), 1);
        chk("stall_err_sticky", int'(err_drop), 1);

        // Push and pop landing in the same cycle with three entries buffered.
        do_reset();
        got.delete();
        for (int c = 0; c < 20; c++) begin
            if (c == 19) chk("pp_count_before", int'(out_count), 3);
            step(c < 4, c == 19, 100 + c, c);
        end
        chk("pp_count_after", int'(out_count), 3);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b1, 0, 0);
        check_order("pp_order", 4, 100);

        // Reset with five results in the pipeline and two buffered.
        do_reset();
        rec_en = 1'b0;
        for (int c = 0; c < 19; c++) step(c < 2 || c >= 14, 1'b0, 200 + c, c);
        chk("mid_count_pre", int'(out_count), 2);
        do_reset();
        chk("mid_out_valid", int'(out_valid), 0);
        chk("mid_out_count", int'(out_count), 0);
        chk("mid_in_ready", int'(in_ready), 1);
        chk("mid_err_drop", int'(err_drop), 0);
        rec_en = 1'b1; got.delete();
        for (int c = 0; c < 25; c++) step(1'b0, 1'b1, 0, 0);
        chk("mid_no_stale", got.size(), 0);

        // Random traffic: bursty producer, consumer alternating between fast and slow phases.
        do_reset();
        rec_en = 1'b0;
        for (int c = 0; c < 600; c++) begin
            iv_r = ($urandom_range(0, 99) < 55);
            or_r = ($urandom_range(0, 99) < (((c / 100) % 2 == 0) ? 75 : 25));
            step(iv_r, or_r, int'($urandom_range(0, 131071)) - 65536,
                 int'($urandom_range(0, 131071)) - 65536);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
